// File: rtl/bms_contactor_sequencer.sv
// Contactor coil sequencer for the battery pack: timed precharge, make-before-break
// handover to the main contactor, ordered opening, and a latched fault lockout.
module bms_contactor_sequencer #(
  parameter int unsigned PRECHARGE_CYCLES  = 20,
  parameter int unsigned OVERLAP_CYCLES    = 4,
  parameter int unsigned OPEN_DELAY_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] fault_state,
  input  logic       shutdown_signal,
  input  logic       enable_req,
  input  logic       clear_req,
  output logic       neg_contactor,
  output logic       pre_contactor,
  output logic       pos_contactor,
  output logic [2:0] seq_state,
  output logic       ready,
  output logic       derate,
  output logic       latched_fault,
  output logic [7:0] trip_count
);

  typedef enum logic [2:0] {
    ST_OPEN    = 3'd0,
    ST_PRECHG  = 3'd1,
    ST_MAIN    = 3'd2,
    ST_CLOSED  = 3'd3,
    ST_OPENING = 3'd4,
    ST_LOCKOUT = 3'd5
  } state_t;

  localparam logic [15:0] PRE_LAST  = 16'(PRECHARGE_CYCLES - 1);
  localparam logic [15:0] OVL_LAST  = 16'(OVERLAP_CYCLES - 1);
  localparam logic [15:0] OPEN_LAST = 16'(OPEN_DELAY_CYCLES - 1);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic        r_latch;
  logic [7:0]  r_trip_cnt;
  logic        r_neg;
  logic        r_pre;
  logic        r_pos;
  logic        r_ready;
  logic        r_derate;

  state_t      w_state_nxt;
  logic [15:0] w_cnt_nxt;
  logic        w_latch_nxt;
  logic [7:0]  w_trip_cnt_nxt;
  logic        w_trip;
  logic        w_trip_evt;
  logic        w_neg_nxt;
  logic        w_pre_nxt;
  logic        w_pos_nxt;
  logic        w_ready_nxt;
  logic        w_derate_nxt;

  assign w_trip = shutdown_signal | fault_state[1];

  always_comb begin
    w_state_nxt = r_state;
    w_latch_nxt = r_latch;
    case (r_state)
      ST_OPEN: begin
        if (w_trip) begin
          w_state_nxt = ST_LOCKOUT;
          w_latch_nxt = 1'b1;
        end else if (enable_req) begin
          w_state_nxt = ST_PRECHG;
        end
      end
      ST_PRECHG: begin
        if (w_trip) begin
          w_state_nxt = ST_OPENING;
          w_latch_nxt = 1'b1;
        end else if (!enable_req) begin
          w_state_nxt = ST_OPENING;
        end else if (r_cnt == PRE_LAST) begin
          w_state_nxt = ST_MAIN;
        end
      end
      ST_MAIN: begin
        if (w_trip) begin
          w_state_nxt = ST_OPENING;
          w_latch_nxt = 1'b1;
        end else if (!enable_req) begin
          w_state_nxt = ST_OPENING;
        end else if (r_cnt == OVL_LAST) begin
          w_state_nxt = ST_CLOSED;
        end
      end
      ST_CLOSED: begin
        if (w_trip) begin
          w_state_nxt = ST_OPENING;
          w_latch_nxt = 1'b1;
        end else if (!enable_req) begin
          w_state_nxt = ST_OPENING;
        end
      end
      ST_OPENING: begin
        // A late trip only arms the latch; the open delay keeps running.
        if (w_trip) w_latch_nxt = 1'b1;
        if (r_cnt == OPEN_LAST) begin
          w_state_nxt = (w_latch_nxt) ? ST_LOCKOUT : ST_OPEN;
        end
      end
      ST_LOCKOUT: begin
        if (clear_req && !w_trip && (fault_state == 2'b00) && !enable_req) begin
          w_state_nxt = ST_OPEN;
          w_latch_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_LOCKOUT;
        w_latch_nxt = 1'b1;
      end
    endcase
  end

  always_comb begin
    w_cnt_nxt      = (w_state_nxt != r_state) ? 16'd0 : r_cnt + 16'd1;
    w_trip_evt     = w_latch_nxt & ~r_latch;
    w_trip_cnt_nxt = r_trip_cnt;
    if (w_trip_evt && (r_trip_cnt != 8'hFF)) w_trip_cnt_nxt = r_trip_cnt + 8'd1;
  end

  // Coil outputs are decoded from the next state so they change on the deciding edge.
  always_comb begin
    w_neg_nxt    = 1'b0;
    w_pre_nxt    = 1'b0;
    w_pos_nxt    = 1'b0;
    w_ready_nxt  = 1'b0;
    w_derate_nxt = 1'b0;
    case (w_state_nxt)
      ST_PRECHG: begin
        w_neg_nxt = 1'b1;
        w_pre_nxt = 1'b1;
      end
      ST_MAIN: begin
        w_neg_nxt = 1'b1;
        w_pre_nxt = 1'b1;
        w_pos_nxt = 1'b1;
      end
      ST_CLOSED: begin
        w_neg_nxt    = 1'b1;
        w_pos_nxt    = 1'b1;
        w_ready_nxt  = 1'b1;
        w_derate_nxt = (fault_state == 2'b01);
      end
      ST_OPENING: w_neg_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_OPEN;
      r_cnt      <= 16'd0;
      r_latch    <= 1'b0;
      r_trip_cnt <= 8'd0;
      r_neg      <= 1'b0;
      r_pre      <= 1'b0;
      r_pos      <= 1'b0;
      r_ready    <= 1'b0;
      r_derate   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_latch    <= w_latch_nxt;
      r_trip_cnt <= w_trip_cnt_nxt;
      r_neg      <= w_neg_nxt;
      r_pre      <= w_pre_nxt;
      r_pos      <= w_pos_nxt;
      r_ready    <= w_ready_nxt;
      r_derate   <= w_derate_nxt;
    end
  end

  assign neg_contactor = r_neg;
  assign pre_contactor = r_pre;
  assign pos_contactor = r_pos;
  assign seq_state     = r_state;
  assign ready         = r_ready;
  assign derate        = r_derate;
  assign latched_fault = r_latch;
  assign trip_count    = r_trip_cnt;

endmodule
